aes_ctr_stream: RTL and testbench
=================================

# aes_ctr_stream

Parametrised AES-CTR streaming controller, the successor to the single-block counter-mode encryption top. Sits between an AXI-Stream-style plaintext/ciphertext path and one external AES block engine (AES_Core plus key_expansion), driven through a start/done port pair. Adds:
- a configurable-width counter field with wrap protection;
- a keystream prefetch FIFO;
- per-byte keep masks and end-of-packet handling.

## Interface
- CTR_WIDTH, 32: number of low nonce bits that increment (1..128); upper 128-CTR_WIDTH bits stay fixed for the session.
- FIFO_DEPTH, 2: keystream prefetch entries; power of two, 2..16.
- clk  in  1  rising-edge clock, single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  session start pulse; sampled only in IDLE.
- key_in  in  128  AES key, captured on an accepted cfg_load.
- nonce_in  in  128  initial counter block, captured on an accepted cfg_load.
- core_key  out  128  registered session key to the engine.
- core_start  out  1  one-cycle request to encrypt core_block.
- core_block  out  128  counter block for the current request; stable from core_start until core_done.
- core_done  in  1  one-cycle completion pulse from the engine.
- core_result  in  128  E(key, core_block); valid while core_done=1.
- s_valid  in  1  plaintext beat valid.
- s_ready  out  1  plaintext beat accepted when s_valid=1 and s_ready=1.
- s_data  in  128  plaintext; byte i is s_data[8i+7:8i].
- s_keep  in  16  byte enables; s_keep[i] qualifies byte i.
- s_last  in  1  final beat of the session.
- m_valid  out  1  ciphertext beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  128  ciphertext; bytes with keep=0 are forced to 0.
- m_keep  out  16  copy of the accepted s_keep.
- m_last  out  1  copy of the accepted s_last.
- busy  out  1  high in any state other than IDLE.
- ctr_wrap  out  1  sticky flag: counter field exhausted. Cleared by reset or by the next accepted cfg_load.

## Operation
- States:
  - IDLE: cfg_load=1 captures key_in→core_key and nonce_in→ctr, clears FIFO and ctr_wrap, then goes to ACTIVE.
  - ACTIVE: plaintext flows; the generator prefetches. An accepted beat with s_last=1 goes to FLUSH.
  - FLUSH: no new core_start. The FIFO is discarded. When no request is outstanding and m_valid=0, go to IDLE.
- Generator:
  - Issues core_start only when all of the following hold: state is ACTIVE, no request is outstanding (at most 1 in flight), FIFO count < FIFO_DEPTH, and ctr_wrap=0.
  - core_block = ctr at issue.
  - On issue, ctr[CTR_WIDTH-1:0] increments modulo 2^CTR_WIDTH; upper bits are unchanged.
  - If the low field is all ones at issue, that block is still issued, then ctr_wrap is set and no further requests are made.
- core_done pushes core_result into the FIFO. In FLUSH, core_done is consumed and the result dropped.
- Data path:
  - s_ready = ACTIVE & FIFO non-empty & (m_valid=0 | m_ready=1).
  - Accepting a beat pops one FIFO entry K, then registers: m_data = (s_data ^ K) with keep=0 bytes zeroed; m_keep = s_keep; m_last = s_last.
  - Each beat consumes one full keystream block regardless of s_keep.
- cfg_load outside IDLE is ignored. s_valid in IDLE/FLUSH is not accepted.
- Keystream exhaustion: with ctr_wrap=1 and the FIFO empty, s_ready stays 0 until reset or a new session.

## Timing
- Reset values:
  - core_key=0, core_start=0, core_block=0;
  - s_ready=0, m_valid=0, m_data=0, m_keep=0, m_last=0;
  - busy=0, ctr_wrap=0;
  - state=IDLE; FIFO empty; no request outstanding.
- Reset asserted mid-operation aborts immediately. A core_done arriving after reset release with no request outstanding is ignored.
- cfg_load at cycle T: busy=1 at T+1; first core_start at T+1.
- core_done and a FIFO pop in the same cycle are both honoured; count is unchanged.
- A push into a full FIFO cannot occur: this is guaranteed by the issue rule, since outstanding requests are counted.
- A new core_start may assert in the cycle after core_done.
- Beat latency: accept at cycle T → m_valid=1 at T+1.
- Backpressure:
  - With m_ready=0, m_valid and m_* hold stable.
  - With m_ready=1, a new beat may be accepted every cycle while the FIFO is non-empty.
- FLUSH→IDLE occurs in the cycle after the last m_valid handshake with nothing outstanding; busy falls with it.

## Test plan
Bench engine model: core_done 4 cycles after core_start, core_result = core_block ^ {16{8'hA5}}.
- Basic: reset; cfg_load with nonce 128'h0…0 and CTR_WIDTH=32; send 3 beats of s_data=0, keep=16'hFFFF, last on beat 3, m_ready=1 → m_data = counter ^ A5-pattern for counter 0, 1, 2; m_last on beat 3 only; busy falls after the flush.
- Partial keep: beat with s_keep=16'h00FF → m_data[127:64]=0; m_keep=16'h00FF.
- Wrap: CTR_WIDTH=8, nonce 128'h…FE → blocks …FE and …FF are issued, ctr_wrap=1, upper bits unchanged; after 2 beats s_ready=0 indefinitely.
- Backpressure: m_ready=0 for 10 cycles → m_* stable; at most FIFO_DEPTH core_start pulses issued; no lost or duplicated keystream after release.
- Mid-stream reset: assert reset_n=0 during an outstanding request → all outputs at reset values; a stale core_done after release causes no FIFO push.
- Ignored load: cfg_load pulsed in ACTIVE with a different key → core_key unchanged; the stream continues.

Source files
------------

// File: rtl/aes_ctr_stream.sv
// AES-CTR streaming controller: drives one external AES block engine through a
// start/done handshake, prefetches keystream into a small FIFO, XORs plaintext beats.
module aes_ctr_stream #(
    parameter int CTR_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cfg_load,
    input  logic [127:0] key_in,
    input  logic [127:0] nonce_in,
    output logic [127:0] core_key,
    output logic         core_start,
    output logic [127:0] core_block,
    input  logic         core_done,
    input  logic [127:0] core_result,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic [15:0]  s_keep,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic [15:0]  m_keep,
    output logic         m_last,
    output logic         busy,
    output logic         ctr_wrap
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    // Only the low CTR_WIDTH bits of the counter block advance.
    localparam logic [127:0] LOW_MASK = (CTR_WIDTH >= 128) ? {128{1'b1}}
                                       : ((128'd1 << CTR_WIDTH) - 128'd1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    logic [1:0]    state_reg,   state_next;
    logic [127:0]  key_reg,     key_next;
    logic [127:0]  ctr_reg,     ctr_next;
    logic          wrap_reg,    wrap_next;
    logic          pending_reg, pending_next;
    logic          start_reg,   start_next;
    logic [127:0]  block_reg,   block_next;
    logic [CW-1:0] cnt_reg,     cnt_next;
    logic [PW-1:0] wr_ptr_reg,  wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg,  rd_ptr_next;
    logic          m_valid_reg, m_valid_next;
    logic [127:0]  m_data_reg,  m_data_next;
    logic [15:0]   m_keep_reg,  m_keep_next;
    logic          m_last_reg,  m_last_next;

    logic [127:0] fifo_mem [FIFO_DEPTH];
    logic [127:0] ks;
    logic [127:0] ct_masked;
    logic         s_ready_int;
    logic         accept;
    logic         go_flush;
    logic         done_ok;
    logic         push;

    assign ks          = fifo_mem[rd_ptr_reg];
    assign s_ready_int = (state_reg == ST_ACTIVE) && (cnt_reg != '0) && (!m_valid_reg || m_ready);
    assign accept      = s_valid && s_ready_int;
    assign go_flush    = accept && s_last;
    // A done with nothing in flight (e.g. straddling a reset) is stale and ignored.
    assign done_ok     = core_done && pending_reg;
    assign push        = done_ok && (state_reg == ST_ACTIVE) && !go_flush;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            assign ct_masked[8*gi +: 8] = s_keep[gi] ? (s_data[8*gi +: 8] ^ ks[8*gi +: 8]) : 8'h00;
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        key_next     = key_reg;
        ctr_next     = ctr_reg;
        wrap_next    = wrap_reg;
        pending_next = pending_reg;
        start_next   = 1'b0;
        block_next   = block_reg;
        cnt_next     = cnt_reg;
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        m_keep_next  = m_keep_reg;
        m_last_next  = m_last_reg;

        if (done_ok) begin
            pending_next = 1'b0;
        end

        if (go_flush) begin
            cnt_next    = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = PW'(wr_ptr_reg + 1'b1);
            end
            if (accept) begin
                rd_ptr_next = PW'(rd_ptr_reg + 1'b1);
            end
            cnt_next = cnt_reg + CW'(push) - CW'(accept);
        end

        if (accept) begin
            m_valid_next = 1'b1;
            m_data_next  = ct_masked;
            m_keep_next  = s_keep;
            m_last_next  = s_last;
        end else if (m_ready) begin
            m_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (cfg_load) begin
                    state_next  = ST_ACTIVE;
                    key_next    = key_in;
                    ctr_next    = nonce_in;
                    wrap_next   = 1'b0;
                    cnt_next    = '0;
                    wr_ptr_next = '0;
                    rd_ptr_next = '0;
                end
            end
            ST_ACTIVE: begin
                if (go_flush) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!pending_next && !m_valid_next) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Decide on next-cycle values so core_start follows cfg_load by one cycle
        // and can re-fire the cycle after core_done.
        if ((state_next == ST_ACTIVE) && !pending_next && (cnt_next < DEPTH_C) && !wrap_next) begin
            start_next   = 1'b1;
            pending_next = 1'b1;
            block_next   = ctr_next;
            wrap_next    = ((ctr_next & LOW_MASK) == LOW_MASK);
            ctr_next     = (ctr_next & ~LOW_MASK) | ((ctr_next + 128'd1) & LOW_MASK);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            key_reg     <= '0;
            ctr_reg     <= '0;
            wrap_reg    <= 1'b0;
            pending_reg <= 1'b0;
            start_reg   <= 1'b0;
            block_reg   <= '0;
            cnt_reg     <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_keep_reg  <= '0;
            m_last_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            key_reg     <= key_next;
            ctr_reg     <= ctr_next;
            wrap_reg    <= wrap_next;
            pending_reg <= pending_next;
            start_reg   <= start_next;
            block_reg   <= block_next;
            cnt_reg     <= cnt_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            m_keep_reg  <= m_keep_next;
            m_last_reg  <= m_last_next;
        end
    end

    // Keystream storage carries no reset; occupancy is tracked by cnt_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= core_result;
        end
    end

    assign core_key   = key_reg;
    assign core_start = start_reg;
    assign core_block = block_reg;
    assign s_ready    = s_ready_int;
    assign m_valid    = m_valid_reg;
    assign m_data     = m_data_reg;
    assign m_keep     = m_keep_reg;
    assign m_last     = m_last_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign ctr_wrap   = wrap_reg;

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Directed bench for aes_ctr_stream with a 4-cycle XOR engine model and an output scoreboard.
module tb_aes_ctr_stream;
    localparam int CTRW = 8;
    localparam int FD   = 2;
    localparam logic [127:0] PAT     = {16{8'hA5}};
    localparam logic [127:0] K1      = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] K2      = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] K3      = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
    localparam logic [127:0] N2      = 128'h0123456789ABCDEF0011223344556600;
    localparam logic [127:0] N3      = 128'hF0E0D0C0B0A090807060504030201010;
    localparam logic [127:0] NW      = 128'hCAFEBABE11223344556677889900A1FE;
    localparam logic [127:0] NW_LAST = 128'hCAFEBABE11223344556677889900A1FF;
    localparam logic [127:0] N4      = 128'h55555555555555555555555555555530;
    localparam logic [127:0] N5      = 128'h77777777777777777777777777777740;
    localparam logic [127:0] N6      = 128'h99999999999999999999999999999999;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cfg_load = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] nonce_in = '0;
    logic [127:0] core_key;
    logic         core_start;
    logic [127:0] core_block;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_data = '0;
    logic [15:0]  s_keep = '0;
    logic         s_last = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [127:0] m_data;
    logic [15:0]  m_keep;
    logic         m_last;
    logic         busy;
    logic         ctr_wrap;

    aes_ctr_stream #(.CTR_WIDTH(CTRW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .key_in(key_in), .nonce_in(nonce_in),
        .core_key(core_key), .core_start(core_start), .core_block(core_block),
        .core_done(core_done), .core_result(core_result),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
        .busy(busy), .ctr_wrap(ctr_wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_start = 0;
    int           sess_start = 0;
    int           n_acc = 0;
    int           sess_acc = 0;
    int           eng_cnt = 0;
    logic         eng_stale = 1'b0;
    logic [127:0] eng_blk = '0;
    logic [127:0] exp_blk = '0;
    logic [127:0] ks_ctr = '0;
    logic [127:0] snap = '0;

    function automatic logic [127:0] ctr_inc(input logic [127:0] x);
        return {x[127:8], 8'(x[7:0] + 8'd1)};
    endfunction

    function automatic logic [127:0] mask_keep(input logic [127:0] d, input logic [15:0] k);
        logic [127:0] r;
        r = d;
        for (int i = 0; i < 16; i++) begin
            if (!k[i]) r[8*i +: 8] = 8'h00;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Engine model: result = block ^ A5 pattern, done 4 cycles after start.
    initial begin
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    core_done   = 1'b1;
                    core_result = eng_blk ^ PAT;
                    if (!eng_stale && reset_n) check("core_block_stable", core_block, eng_blk);
                end
            end
            if (core_start === 1'b1) begin
                n_start++;
                eng_stale = 1'b0;
                eng_blk   = core_block;
                eng_cnt   = 4;
                check("core_block_seq", core_block, exp_blk);
                exp_blk = ctr_inc(exp_blk);
            end
        end
    end

    // Output scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                n_cmp++;
                assert (sb_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_unexpected_beat: observed data %h expected no beat", m_data);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_data", m_data, e.d);
                    check("sb_keep", 128'(m_keep), 128'(e.k));
                    check("sb_last", 128'(m_last), 128'(e.l));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [127:0] k, input logic [127:0] n);
        cfg_load   = 1'b1;
        key_in     = k;
        nonce_in   = n;
        exp_blk    = n;
        ks_ctr     = n;
        sess_start = n_start;
        sess_acc   = n_acc;
        @(posedge clk); #1;
        cfg_load   = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        logic ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                sb_q.push_back({mask_keep(d ^ ks_ctr ^ PAT, k), k, l});
                ks_ctr = ctr_inc(ks_ctr);
                n_acc++;
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("send_accepted", 128'(ok), 128'(1'b1));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check({tag, "_busy_low"}, 128'(busy), 128'(1'b0));
        check({tag, "_sb_empty"}, 128'(sb_q.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_core_key"}, core_key, 128'(0));
        check({p, "_core_start"}, 128'(core_start), 128'(0));
        check({p, "_core_block"}, core_block, 128'(0));
        check({p, "_s_ready"}, 128'(s_ready), 128'(0));
        check({p, "_m_valid"}, 128'(m_valid), 128'(0));
        check({p, "_m_data"}, m_data, 128'(0));
        check({p, "_m_keep"}, 128'(m_keep), 128'(0));
        check({p, "_m_last"}, 128'(m_last), 128'(0));
        check({p, "_busy"}, 128'(busy), 128'(0));
        check({p, "_ctr_wrap"}, 128'(ctr_wrap), 128'(0));
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic: three zero beats, counter 0,1,2
        m_ready = 1'b1;
        load(K1, 128'h0);
        @(negedge clk);
        check("load_busy", 128'(busy), 128'(1'b1));
        check("load_core_start", 128'(core_start), 128'(1'b1));
        check("load_core_key", core_key, K1);
        @(posedge clk); #1;
        send_beat(128'h0, 16'hFFFF, 1'b0);
        send_beat(128'h0, 16'hFFFF, 1'b0);
        send_beat(128'h0, 16'hFFFF, 1'b1);
        wait_idle("basic");

        // Partial keep
        load(K1, N2);
        send_beat(128'h1111222233334444AAAABBBBCCCCDDDD, 16'h00FF, 1'b0);
        send_beat(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 16'hF0F0, 1'b1);
        wait_idle("keep");

        // Backpressure
        m_ready = 1'b0;
        load(K1, N3);
        send_beat(128'h13579BDF02468ACE13579BDF02468ACE, 16'hFFFF, 1'b0);
        @(negedge clk);
        snap = m_data;
        repeat (10) @(negedge clk);
        check("bp_m_valid", 128'(m_valid), 128'(1'b1));
        check("bp_m_data", m_data, snap);
        check("bp_s_ready", 128'(s_ready), 128'(1'b0));
        check("bp_prefetch", 128'((n_start - sess_start) - (n_acc - sess_acc)), 128'(FD));
        @(posedge clk); #1;
        m_ready = 1'b1;
        send_beat(128'hFEDCBA9876543210FEDCBA9876543210, 16'hFFFF, 1'b0);
        send_beat(128'h00000000FFFFFFFF00000000FFFFFFFF, 16'hFFFF, 1'b1);
        wait_idle("bp");

        // Counter wrap with an 8-bit field
        load(K2, NW);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("wrap_flag", 128'(ctr_wrap), 128'(1'b1));
        check("wrap_starts", 128'(n_start - sess_start), 128'(2));
        check("wrap_last_block", core_block, NW_LAST);
        @(posedge clk); #1;
        send_beat(128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 16'hFFFF, 1'b0);
        send_beat(128'h5555555555555555555555555555555A, 16'hFFFF, 1'b0);
        s_valid = 1'b1;
        s_data  = 128'h1;
        s_keep  = 16'hFFFF;
        s_last  = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("wrap_s_ready_low", 128'(s_ready), 128'(1'b0));
        check("wrap_no_more_starts", 128'(n_start - sess_start), 128'(2));
        check("wrap_still_busy", 128'(busy), 128'(1'b1));
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Mid-stream reset with a request in flight
        load(K1, N4);
        @(negedge clk);
        check("mid_outstanding_start", 128'(core_start), 128'(1'b1));
        @(posedge clk); #1;
        reset_n   = 1'b0;
        eng_stale = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("stale_busy", 128'(busy), 128'(1'b0));
        check("stale_s_ready", 128'(s_ready), 128'(1'b0));
        check("stale_core_start", 128'(core_start), 128'(1'b0));
        @(posedge clk); #1;
        load(K1, N4);
        send_beat(128'h0123012301230123012301230123ABCD, 16'hFFFF, 1'b0);
        send_beat(128'h89AB89AB89AB89AB89AB89AB89AB0001, 16'h0F0F, 1'b1);
        wait_idle("post_reset");

        // Ignored load while ACTIVE
        load(K2, N5);
        send_beat(128'h31415926535897932384626433832795, 16'hFFFF, 1'b0);
        cfg_load = 1'b1;
        key_in   = K3;
        nonce_in = N6;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        @(negedge clk);
        check("ign_core_key", core_key, K2);
        check("ign_busy", 128'(busy), 128'(1'b1));
        @(posedge clk); #1;
        send_beat(128'h27182818284590452353602874713527, 16'hFFFF, 1'b0);
        send_beat(128'h16180339887498948482045868343656, 16'hFFFF, 1'b1);
        wait_idle("ign");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
